// File: rtl/sdram_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master port among N_REQ
// single-beat requesters. The grant is held for a whole transaction: issue,
// plus the read-data wait for reads. Every grant is followed by one IDLE cycle.
module sdram_master_arbiter #(
  parameter int N_REQ   = 6,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ*32-1:0]  req_address,
  input  logic [N_REQ-1:0]     req_read,
  input  logic [N_REQ-1:0]     req_write,
  input  logic [N_REQ*32-1:0]  req_writedata,
  output logic [N_REQ-1:0]     req_waitrequest,
  output logic [31:0]          req_readdata,
  output logic [N_REQ-1:0]     req_readdatavalid,
  input  logic                 master_waitrequest,
  output logic [31:0]          master_address,
  output logic                 master_read,
  output logic                 master_write,
  output logic [31:0]          master_writedata,
  input  logic [31:0]          master_readdata,
  input  logic                 master_readdatavalid,
  output logic [7:0]           grant_id,
  output logic                 err_timeout
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE_RD, WAIT_RDV, ISSUE_WR} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            err_q, err_d;

  logic [31:0]     addr_arr  [N_REQ];
  logic [31:0]     wdata_arr [N_REQ];
  logic [N_REQ-1:0] active;
  logic [IW-1:0]   rr_next;
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW:0]     cand;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_address[g*32 +: 32];
    assign wdata_arr[g] = req_writedata[g*32 +: 32];
  end

  // A requester asking for both a read and a write counts once; read wins later.
  assign active       = req_read | req_write;
  assign rr_next      = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
  assign req_readdata = master_readdata;
  assign err_timeout  = err_q;

  // Round-robin search: first active requester at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found = 1'b0;
    pick  = rr_ptr_q;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!found && active[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  // Next-state and output decode; outputs hold their IDLE values unless granted.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    rr_ptr_d          = rr_ptr_q;
    timer_d           = timer_q;
    err_d             = err_q;
    master_read       = 1'b0;
    master_write      = 1'b0;
    master_address    = '1;
    master_writedata  = '0;
    req_waitrequest   = '1;
    req_readdatavalid = '0;
    grant_id          = 8'hFF;

    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          state_d = req_read[pick] ? ISSUE_RD : ISSUE_WR;
        end
      end

      ISSUE_RD, ISSUE_WR: begin
        grant_id                 = 8'(owner_q);
        master_read              = (state_q == ISSUE_RD);
        master_write             = (state_q == ISSUE_WR);
        master_address           = addr_arr[owner_q];
        master_writedata         = wdata_arr[owner_q];
        req_waitrequest[owner_q] = master_waitrequest;
        if (!master_waitrequest) begin
          if (state_q == ISSUE_RD) begin
            state_d = WAIT_RDV;
            timer_d = '0;
          end else begin
            state_d  = IDLE;
            rr_ptr_d = rr_next;
          end
        end
      end

      WAIT_RDV: begin
        grant_id                   = 8'(owner_q);
        req_readdatavalid[owner_q] = master_readdatavalid;
        if (master_readdatavalid) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Data never came back: free the port and flag it; the owner is left hanging.
          state_d  = IDLE;
          rr_ptr_d = rr_next;
          err_d    = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset to the IDLE/no-error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together at the edge.
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_sdram_master_arbiter.sv
// Self-checking bench for sdram_master_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level round-robin model.
module tb_sdram_master_arbiter;

  localparam int N = 6;
  localparam logic [31:0] RD_KEY = 32'h5A5A_0F0F;

  logic           clk;
  logic           rst_n;
  logic [N*32-1:0] req_address;
  logic [N-1:0]   req_read;
  logic [N-1:0]   req_write;
  logic [N*32-1:0] req_writedata;
  logic [N-1:0]   req_waitrequest;
  logic [31:0]    req_readdata;
  logic [N-1:0]   req_readdatavalid;
  logic           master_waitrequest;
  logic [31:0]    master_address;
  logic           master_read;
  logic           master_write;
  logic [31:0]    master_writedata;
  logic [31:0]    master_readdata;
  logic           master_readdatavalid;
  logic [7:0]     grant_id;
  logic           err_timeout;

  int checks = 0;
  int errors = 0;

  sdram_master_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_address          (req_address),
    .req_read             (req_read),
    .req_write            (req_write),
    .req_writedata        (req_writedata),
    .req_waitrequest      (req_waitrequest),
    .req_readdata         (req_readdata),
    .req_readdatavalid    (req_readdatavalid),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .grant_id             (grant_id),
    .err_timeout          (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed handshake-level outputs packed as {grant, rd, wr, waitreq, rdv, err}.
  function automatic logic [22:0] snap();
    return {grant_id, master_read, master_write, req_waitrequest, req_readdatavalid, err_timeout};
  endfunction

  function automatic logic [22:0] pk(input logic [7:0] g, input logic r, input logic w,
                                     input logic [5:0] wq, input logic [5:0] rv, input logic e);
    return {g, r, w, wq, rv, e};
  endfunction

  // Reference round-robin choice: first active index starting at ptr, modulo N.
  function automatic int rr_pick(input logic [5:0] act, input int ptr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (act[j]) return j;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_address          = '0;
    req_writedata        = '0;
    req_read             = '0;
    req_write            = '0;
    master_waitrequest   = 1'b0;
    master_readdata      = '0;
    master_readdatavalid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    req_read = 6'h3F;
    master_readdatavalid = 1'b1;
    #2;
    checks++;
    if (snap() !== pk(8'hFF, 0, 0, 6'h3F, 6'h00, 0)) begin
      errors++; $display("FAIL reset_outputs got %h exp %h", snap(), pk(8'hFF, 0, 0, 6'h3F, 6'h00, 0));
    end
    checks++;
    if (master_address !== 32'hFFFF_FFFF || master_writedata !== 32'h0) begin
      errors++; $display("FAIL reset_bus got addr %h wdata %h exp addr ffffffff wdata 0", master_address, master_writedata);
    end
    @(posedge clk); #1;
    checks++;
    if (snap() !== pk(8'hFF, 0, 0, 6'h3F, 6'h00, 0)) begin
      errors++; $display("FAIL reset_held got %h exp %h", snap(), pk(8'hFF, 0, 0, 6'h3F, 6'h00, 0));
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    req_read = 6'b000100;
    req_address[2*32 +: 32] = 32'h100;
    #1;
    checks++;
    if (snap() !== pk(8'hFF, 0, 0, 6'h3F, 0, 0)) begin
      errors++; $display("FAIL t1_request_cycle got %h exp %h", snap(), pk(8'hFF, 0, 0, 6'h3F, 0, 0));
    end
    tick(); #1;
    checks++;
    if (snap() !== pk(8'd2, 1, 0, 6'b111011, 0, 0) || master_address !== 32'h100) begin
      errors++; $display("FAIL t1_issue got %h addr %h exp %h addr 100", snap(), master_address, pk(8'd2, 1, 0, 6'b111011, 0, 0));
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      req_read = '0;
      #1;
      checks++;
      if (snap() !== pk(8'd2, 0, 0, 6'h3F, 0, 0)) begin
        errors++; $display("FAIL t1_wait%0d got %h exp %h", k, snap(), pk(8'd2, 0, 0, 6'h3F, 0, 0));
      end
    end
    tick();
    master_readdatavalid = 1'b1;
    master_readdata = 32'h5;
    #1;
    checks++;
    if (req_readdatavalid !== 6'b000100 || req_readdata !== 32'h5) begin
      errors++; $display("FAIL t1_rdv got rdv %b data %h exp rdv 000100 data 5", req_readdatavalid, req_readdata);
    end
    tick();
    master_readdatavalid = 1'b0;
    #1;
    checks++;
    if (snap() !== pk(8'hFF, 0, 0, 6'h3F, 0, 0)) begin
      errors++; $display("FAIL t1_back_idle got %h exp %h", snap(), pk(8'hFF, 0, 0, 6'h3F, 0, 0));
    end
  endtask

  task automatic test_contention();
    int exp_seq [6] = '{0, 3, 5, 0, 3, 5};
    int n;
    logic [5:0] wq;
    n = 0;
    apply_reset();
    req_read = 6'b101001;
    master_readdatavalid = 1'b1;
    master_readdata = 32'hABCD_0001;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (master_read) begin
        wq = '1;
        if (n < 6) wq[exp_seq[n]] = 1'b0;
        checks++;
        if (n >= 6 || grant_id !== 8'(exp_seq[n]) || req_waitrequest !== wq) begin
          errors++; $display("FAIL t2_grant%0d got id %0d wq %b exp id %0d wq %b", n, grant_id,
                             req_waitrequest, (n < 6) ? exp_seq[n] : -1, wq);
        end
        n++;
      end else begin
        checks++;
        if (req_waitrequest !== 6'h3F) begin
          errors++; $display("FAIL t2_nonowner_wait cycle %0d got %b exp 111111", c, req_waitrequest);
        end
        if (grant_id === 8'hFF) begin
          checks++;
          if (req_readdatavalid !== 6'h00) begin
            errors++; $display("FAIL t2_idle_rdv cycle %0d got %b exp 000000", c, req_readdatavalid);
          end
        end
      end
      tick();
    end
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL t2_grant_count got %0d exp 6", n);
    end
  endtask

  task automatic test_write_wait();
    apply_reset();
    req_write = 6'b000010;
    req_address[1*32 +: 32]   = 32'h0000_2000;
    req_writedata[1*32 +: 32] = 32'hDEAD_BEEF;
    master_waitrequest = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      tick();
      master_waitrequest = (k < 4);
      #1;
      checks++;
      if (snap() !== pk(8'd1, 0, 1, (k < 4) ? 6'h3F : 6'b111101, 0, 0) ||
          master_address !== 32'h0000_2000 || master_writedata !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL t3_issue%0d got %h addr %h wd %h exp %h", k, snap(), master_address,
                           master_writedata, pk(8'd1, 0, 1, (k < 4) ? 6'h3F : 6'b111101, 0, 0));
      end
    end
    tick();
    req_write = '0;
    req_read  = 6'b000110;
    master_waitrequest = 1'b0;
    #1;
    checks++;
    if (snap() !== pk(8'hFF, 0, 0, 6'h3F, 0, 0)) begin
      errors++; $display("FAIL t3_idle got %h exp %h", snap(), pk(8'hFF, 0, 0, 6'h3F, 0, 0));
    end
    tick(); #1;
    checks++;
    if (grant_id !== 8'd2 || master_read !== 1'b1) begin
      errors++; $display("FAIL t3_rr_ptr got id %0d rd %b exp id 2 rd 1", grant_id, master_read);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req_read = 6'b000001;
    req_address[0 +: 32] = 32'h40;
    #1;
    tick(); #1;
    checks++;
    if (snap() !== pk(8'd0, 1, 0, 6'b111110, 0, 0)) begin
      errors++; $display("FAIL t4_issue got %h exp %h", snap(), pk(8'd0, 1, 0, 6'b111110, 0, 0));
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      req_read = '0;
      #1;
      checks++;
      if (snap() !== pk(8'd0, 0, 0, 6'h3F, 0, 0)) begin
        errors++; $display("FAIL t4_wait%0d got %h exp %h", k, snap(), pk(8'd0, 0, 0, 6'h3F, 0, 0));
      end
    end
    tick();
    req_read = 6'b001000;
    req_address[3*32 +: 32] = 32'h300;
    #1;
    checks++;
    if (snap() !== pk(8'hFF, 0, 0, 6'h3F, 0, 1)) begin
      errors++; $display("FAIL t4_expired got %h exp %h", snap(), pk(8'hFF, 0, 0, 6'h3F, 0, 1));
    end
    tick(); #1;
    checks++;
    if (snap() !== pk(8'd3, 1, 0, 6'b110111, 0, 1) || master_address !== 32'h300) begin
      errors++; $display("FAIL t4_next_grant got %h addr %h exp %h", snap(), master_address, pk(8'd3, 1, 0, 6'b110111, 0, 1));
    end
    tick();
    req_read = '0;
    master_readdatavalid = 1'b1;
    master_readdata = 32'h33;
    #1;
    checks++;
    if (snap() !== pk(8'd3, 0, 0, 6'h3F, 6'b001000, 1) || req_readdata !== 32'h33) begin
      errors++; $display("FAIL t4_next_rdv got %h data %h exp %h data 33", snap(), req_readdata, pk(8'd3, 0, 0, 6'h3F, 6'b001000, 1));
    end
    tick();
    master_readdatavalid = 1'b0;
    #1;
    checks++;
    if (snap() !== pk(8'hFF, 0, 0, 6'h3F, 0, 1)) begin
      errors++; $display("FAIL t4_sticky got %h exp %h", snap(), pk(8'hFF, 0, 0, 6'h3F, 0, 1));
    end
  endtask

  // Runs straight after test_timeout so err_timeout starts at 1.
  task automatic test_reset_mid_read();
    req_read = 6'b010000;
    req_address[4*32 +: 32] = 32'h80;
    #1;
    tick();
    #1;
    tick();
    req_read = '0;
    #1;
    checks++;
    if (snap() !== pk(8'd4, 0, 0, 6'h3F, 0, 1)) begin
      errors++; $display("FAIL t5_in_wait got %h exp %h", snap(), pk(8'd4, 0, 0, 6'h3F, 0, 1));
    end
    tick();
    master_readdatavalid = 1'b1;
    master_readdata = 32'h77;
    rst_n = 1'b0;
    #1;
    checks++;
    if (snap() !== pk(8'hFF, 0, 0, 6'h3F, 0, 0) || master_address !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL t5_async got %h addr %h exp %h", snap(), master_address, pk(8'hFF, 0, 0, 6'h3F, 0, 0));
    end
    tick();
    checks++;
    if (snap() !== pk(8'hFF, 0, 0, 6'h3F, 0, 0)) begin
      errors++; $display("FAIL t5_held got %h exp %h", snap(), pk(8'hFF, 0, 0, 6'h3F, 0, 0));
    end
    rst_n = 1'b1;
    tick(); #1;
    checks++;
    if (snap() !== pk(8'hFF, 0, 0, 6'h3F, 0, 0)) begin
      errors++; $display("FAIL t5_stale_rdv got %h exp %h", snap(), pk(8'hFF, 0, 0, 6'h3F, 0, 0));
    end
    master_readdatavalid = 1'b0;
  endtask

  task automatic test_read_write_same();
    apply_reset();
    req_read  = 6'b010000;
    req_write = 6'b010000;
    req_address[4*32 +: 32] = 32'hC0;
    #1;
    tick(); #1;
    checks++;
    if (snap() !== pk(8'd4, 1, 0, 6'b101111, 0, 0)) begin
      errors++; $display("FAIL t6_read_wins got %h exp %h", snap(), pk(8'd4, 1, 0, 6'b101111, 0, 0));
    end
    tick();
    req_read  = '0;
    req_write = '0;
    master_readdatavalid = 1'b1;
    master_readdata = 32'h44;
    #1;
    checks++;
    if (snap() !== pk(8'd4, 0, 0, 6'h3F, 6'b010000, 0)) begin
      errors++; $display("FAIL t6_rdv got %h exp %h", snap(), pk(8'd4, 0, 0, 6'h3F, 6'b010000, 0));
    end
    tick();
    master_readdatavalid = 1'b0;
    #1;
    checks++;
    if (snap() !== pk(8'hFF, 0, 0, 6'h3F, 0, 0)) begin
      errors++; $display("FAIL t6_idle got %h exp %h", snap(), pk(8'hFF, 0, 0, 6'h3F, 0, 0));
    end
  endtask

  // Random requesters and a random-latency SDRAM slave; the model tracks whole
  // transactions (who owns the port and whether data is still due) and the pointer.
  task automatic test_random();
    bit [5:0]    pr, pw, wd;
    logic [31:0] ra [6];
    logic [31:0] rw [6];
    bit          busy, issued, prev_idle, cur_rd, sp, rdv_real;
    int          cur, ptr, lat, done_cnt;
    logic [5:0]  prev_act, prev_rd, wq, rv;
    logic [31:0] saddr;
    logic [22:0] exp_s;
    pr = '0; pw = '0; wd = '0;
    busy = 0; issued = 0; prev_idle = 1; cur_rd = 0; sp = 0;
    cur = 0; ptr = 0; lat = 0; done_cnt = 0;
    prev_act = '0; prev_rd = '0; saddr = '0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rw[i] = '0; end
    apply_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pr[i] && !pw[i] && !wd[i] && $urandom_range(2) == 0) begin
          if ($urandom_range(1) == 1) pr[i] = 1'b1; else pw[i] = 1'b1;
          ra[i] = $urandom;
          rw[i] = $urandom;
        end
        req_address[i*32 +: 32]   = ra[i];
        req_writedata[i*32 +: 32] = rw[i];
      end
      req_read  = pr;
      req_write = pw;
      master_waitrequest = ($urandom_range(1) == 0);
      rdv_real = 1'b0;
      if (sp && lat == 0) begin
        master_readdatavalid = 1'b1;
        master_readdata = saddr ^ RD_KEY;
        rdv_real = 1'b1;
      end else begin
        if (sp) lat--;
        master_readdatavalid = !sp && ($urandom_range(7) == 0);
        master_readdata = $urandom;
      end
      #1;
      if (!busy && prev_idle && prev_act != 0) begin
        cur = rr_pick(prev_act, ptr);
        cur_rd = prev_rd[cur];
        busy = 1; issued = 0;
      end
      wq = '1; rv = '0;
      if (!busy) exp_s = pk(8'hFF, 0, 0, 6'h3F, 0, 0);
      else if (!issued) begin
        wq[cur] = master_waitrequest;
        exp_s = pk(8'(cur), cur_rd, !cur_rd, wq, 0, 0);
      end else begin
        rv[cur] = master_readdatavalid;
        exp_s = pk(8'(cur), 0, 0, 6'h3F, rv, 0);
      end
      checks++;
      if (snap() !== exp_s) begin
        errors++; $display("FAIL rnd_ctrl cycle %0d got %h exp %h", cyc, snap(), exp_s);
      end
      if (busy && !issued) begin
        checks++;
        if (master_address !== ra[cur] || master_writedata !== rw[cur]) begin
          errors++; $display("FAIL rnd_bus cycle %0d got %h/%h exp %h/%h", cyc, master_address, master_writedata, ra[cur], rw[cur]);
        end
      end else if (!busy) begin
        checks++;
        if (master_address !== 32'hFFFF_FFFF) begin
          errors++; $display("FAIL rnd_idle_addr cycle %0d got %h exp ffffffff", cyc, master_address);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_readdatavalid[i]) begin
          checks++;
          if (!wd[i] || req_readdata !== (ra[i] ^ RD_KEY)) begin
            errors++; $display("FAIL rnd_rdata req %0d got %h exp %h pending %b", i, req_readdata, ra[i] ^ RD_KEY, wd[i]);
          end
          wd[i] = 1'b0;
        end
        if ((pr[i] || pw[i]) && !req_waitrequest[i]) begin
          if (pr[i]) wd[i] = 1'b1;
          pr[i] = 1'b0;
          pw[i] = 1'b0;
        end
      end
      if (rdv_real) sp = 1'b0;
      if (master_read && !master_waitrequest) begin
        sp = 1'b1;
        saddr = master_address;
        lat = $urandom_range(4);
      end
      prev_idle = !busy;
      prev_act  = req_read | req_write;
      prev_rd   = req_read;
      if (busy && !issued && !master_waitrequest) begin
        if (cur_rd) issued = 1;
        else begin busy = 0; ptr = (cur + 1) % N; done_cnt++; end
      end else if (busy && issued && master_readdatavalid) begin
        busy = 0; ptr = (cur + 1) % N; done_cnt++;
      end
      tick();
    end
    checks++;
    if (done_cnt < 100) begin
      errors++; $display("FAIL rnd_progress got %0d exp at least 100", done_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_wait();
    test_timeout();
    test_reset_mid_read();
    test_read_write_same();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
